// File: rtl/wb_trace_pkg.sv
// Shared types and record formatting for the writeback trace transmitter.
// WB_TRACE_CHECKSUM_EN appends an XOR checksum byte to every record.
package wb_trace_pkg;

  localparam logic [7:0] HDR_WB  = 8'hA5;
  localparam logic [7:0] HDR_END = 8'h5A;

`ifdef WB_TRACE_CHECKSUM_EN
  localparam int REC_BYTES = 11;
`else
  localparam int REC_BYTES = 10;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        is_end;
  } trace_rec_t;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} ser_state_e;

  function automatic logic [7:0] rec_hdr(trace_rec_t r);
    return r.is_end ? HDR_END : HDR_WB;
  endfunction

`ifdef WB_TRACE_CHECKSUM_EN
  function automatic logic [7:0] rec_csum(trace_rec_t r);
    return rec_hdr(r) ^ r.pc[31:24] ^ r.pc[23:16] ^ r.pc[15:8] ^ r.pc[7:0] ^
           {3'b000, r.wnum} ^
           r.wdata[31:24] ^ r.wdata[23:16] ^ r.wdata[15:8] ^ r.wdata[7:0];
  endfunction
`endif

  // Wire order of a record: header, pc, wnum, wdata, all MSB first.
  function automatic logic [7:0] rec_byte(trace_rec_t r, logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = rec_hdr(r);
      4'd1:    b = r.pc[31:24];
      4'd2:    b = r.pc[23:16];
      4'd3:    b = r.pc[15:8];
      4'd4:    b = r.pc[7:0];
      4'd5:    b = {3'b000, r.wnum};
      4'd6:    b = r.wdata[31:24];
      4'd7:    b = r.wdata[23:16];
      4'd8:    b = r.wdata[15:8];
      4'd9:    b = r.wdata[7:0];
`ifdef WB_TRACE_CHECKSUM_EN
      4'd10:   b = rec_csum(r);
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wb_trace_tx_if.sv
// Byte stream from the trace transmitter to its sink (normally a UART).
interface wb_trace_tx_if;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/wb_trace_fifo.sv
// Dual-push / single-pop record FIFO. Port A carries normal records and
// is refused while it would consume the slot held back for the end record.
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_a_i,
  input  trace_rec_t             data_a_i,
  input  logic                   push_b_i,
  input  trace_rec_t             data_b_i,
  input  logic                   resv_i,
  input  logic                   pop_i,
  output trace_rec_t             head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] free_o,
  output logic                   acc_a_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  trace_rec_t    mem_q [DEPTH];
  trace_rec_t    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] free_w, need_a;
  logic          pop_ok, acc_a, acc_b;

  always_comb begin
    pop_ok = pop_i && (cnt_q != '0);
    // A same-cycle pop frees its slot before either push is judged.
    free_w = CW'(DEPTH) - cnt_q + CW'(pop_ok);
    need_a = (resv_i || push_b_i) ? CW'(2) : CW'(1);
    acc_a  = push_a_i && (free_w >= need_a);
    acc_b  = push_b_i && (free_w >= (acc_a ? CW'(2) : CW'(1)));

    mem_d = mem_q;
    if (acc_a) mem_d[wr_ptr_q] = data_a_i;
    if (acc_b) mem_d[wr_ptr_q + PW'(acc_a)] = data_b_i;

    wr_ptr_d = wr_ptr_q + PW'(acc_a) + PW'(acc_b);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    cnt_d    = cnt_q - CW'(pop_ok) + CW'(acc_a) + CW'(acc_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign free_o  = CW'(DEPTH) - cnt_q;
  assign acc_a_o = acc_a;

endmodule

// File: rtl/wb_trace_tx.sv
// Writeback trace producer: capture -> FIFO -> byte serialiser.
// WB_TRACE_CHECKSUM_EN adds a trailing XOR byte to each record.
module wb_trace_tx
  import wb_trace_pkg::*;
#(
  parameter int          DEPTH  = 8,
  parameter logic [31:0] END_PC = 32'h80000010
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [31:0]         debug_wb_pc,
  input  logic [3:0]          debug_wb_rf_wen,
  input  logic [4:0]          debug_wb_rf_wnum,
  input  logic [31:0]         debug_wb_rf_wdata,
  wb_trace_tx_if.master       tx,
  output logic                overflow,
  output logic [15:0]         drop_cnt,
  output logic                done
);

  localparam trace_rec_t END_REC = '{pc: END_PC, wnum: 5'd0, wdata: 32'd0, is_end: 1'b1};

  logic       end_seen_q, end_seen_d;
  logic       cap_norm_q, cap_norm_d, cap_end_q, cap_end_d;
  trace_rec_t cap_rec_q, cap_rec_d;
  logic       overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] wdata_m;
  logic       drop;

  ser_state_e state_q, state_d;
  trace_rec_t rec_q, rec_d;
  logic [3:0] idx_q, idx_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       done_q, done_d;

  trace_rec_t          fifo_head;
  logic                fifo_empty, fifo_full, fifo_acc, fifo_pop;
  logic [$clog2(DEPTH):0] fifo_free;

  wb_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_a_i (cap_norm_q),
    .data_a_i (cap_rec_q),
    .push_b_i (cap_end_q),
    .data_b_i (END_REC),
    .resv_i   (!end_seen_q),
    .pop_i    (fifo_pop),
    .head_o   (fifo_head),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full),
    .free_o   (fifo_free),
    .acc_a_o  (fifo_acc)
  );

  // Events are registered once, then pushed; end_seen closes capture at once.
  always_comb begin
    wdata_m = debug_wb_rf_wdata & {{8{debug_wb_rf_wen[3]}}, {8{debug_wb_rf_wen[2]}},
                                   {8{debug_wb_rf_wen[1]}}, {8{debug_wb_rf_wen[0]}}};
    cap_norm_d = en && (|debug_wb_rf_wen) && (debug_wb_rf_wnum != 5'd0) && !end_seen_q;
    cap_end_d  = en && (debug_wb_pc == END_PC) && !end_seen_q;
    end_seen_d = end_seen_q | cap_end_d;
    cap_rec_d  = '{pc: debug_wb_pc, wnum: debug_wb_rf_wnum, wdata: wdata_m, is_end: 1'b0};

    drop       = cap_norm_q && !fifo_acc;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_comb begin
    state_d     = state_q;
    rec_d       = rec_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = done_q;
    fifo_pop    = 1'b0;
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        fifo_pop    = 1'b1;
        rec_d       = fifo_head;
        idx_d       = 4'd0;
        out_valid_d = 1'b1;
        out_data_d  = rec_byte(fifo_head, 4'd0);
        state_d     = S_SEND;
      end
      S_SEND: if (out_valid_q && tx.out_ready) begin
        if (idx_q == 4'(REC_BYTES - 1)) begin
          out_valid_d = 1'b0;
          done_d      = rec_q.is_end;
          state_d     = rec_q.is_end ? S_DONE : S_IDLE;
        end else begin
          idx_d      = idx_q + 4'd1;
          out_data_d = rec_byte(rec_q, idx_q + 4'd1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      end_seen_q  <= 1'b0;
      cap_norm_q  <= 1'b0;
      cap_end_q   <= 1'b0;
      cap_rec_q   <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      state_q     <= S_IDLE;
      rec_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      end_seen_q  <= end_seen_d;
      cap_norm_q  <= cap_norm_d;
      cap_end_q   <= cap_end_d;
      cap_rec_q   <= cap_rec_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      state_q     <= state_d;
      rec_q       <= rec_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  // The held-back slot must still be free when the end record arrives.
  always_comb if (cap_end_q) assert (!fifo_full && (fifo_free != '0));

  assign tx.out_valid = out_valid_q;
  assign tx.out_data  = out_data_q;
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;
  assign done         = done_q;

endmodule

// File: tb/tb_wb_trace_tx.sv
// Bench for wb_trace_tx: vector table, random bursts against a byte-stream
// model, and hand sequences for overflow, end record and reset.
module tb_wb_trace_tx;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] END_PC = 32'h80000010;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [31:0] pc_i, wd_i;
  logic [3:0]  wen_i;
  logic [4:0]  wnum_i;
  logic        overflow, done;
  logic [15:0] drop_cnt;

  wb_trace_tx_if tx_if ();

  wb_trace_tx #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .en                (en),
    .debug_wb_pc       (pc_i),
    .debug_wb_rf_wen   (wen_i),
    .debug_wb_rf_wnum  (wnum_i),
    .debug_wb_rf_wdata (wd_i),
    .tx                (tx_if),
    .overflow          (overflow),
    .drop_cnt          (drop_cnt),
    .done              (done)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    bit          exp_rec;
    logic [31:0] exp_word;
  } vec_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int n);
    repeat (n) tick();
  endtask

  // Expected wire image of one record.
  task automatic push_exp(logic [7:0] hdr, logic [31:0] pc, logic [4:0] wn, logic [31:0] wd);
    logic [7:0] b [10];
    logic [7:0] x;
    b = '{hdr, pc[31:24], pc[23:16], pc[15:8], pc[7:0], {3'b000, wn},
          wd[31:24], wd[23:16], wd[15:8], wd[7:0]};
    x = 8'h00;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(b[i]);
      x = x ^ b[i];
    end
`ifdef WB_TRACE_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  function automatic logic [31:0] mask_wd(logic [31:0] wd, logic [3:0] wen);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (wen[i]) m[8*i +: 8] = wd[8*i +: 8];
    return m;
  endfunction

  task automatic drive_ev(logic [31:0] pc, logic [3:0] wen, logic [4:0] wn, logic [31:0] wd);
    en = 1'b1; pc_i = pc; wen_i = wen; wnum_i = wn; wd_i = wd;
    tick();
    en = 1'b0; wen_i = 4'h0;
  endtask

  task automatic cmp_stream(string name);
    chk({name, " len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s byte%0d", name, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  // Sampled mid-cycle: the transfer it records happens at the next rising edge.
  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall valid", tx_if.out_valid, 1);
        chk("stall data", tx_if.out_data, prev_data);
      end
      if (tx_if.out_valid && tx_if.out_ready) rx_q.push_back(tx_if.out_data);
      prev_stall = tx_if.out_valid && !tx_if.out_ready;
      prev_data  = tx_if.out_data;
    end
  end

  initial begin
    vec_t        vecs [6];
    logic [31:0] pc, wd;
    logic [3:0]  wen;
    logic [4:0]  wn;
    int          k;

    vecs[0] = '{32'h80000000, 4'hF, 5'd5,  32'h12345678, 1'b1, 32'h12345678};
    vecs[1] = '{32'h80000004, 4'h3, 5'd7,  32'hDEADBEEF, 1'b1, 32'h0000BEEF};
    vecs[2] = '{32'h80000008, 4'h0, 5'd7,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[3] = '{32'h8000000C, 4'hF, 5'd0,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[4] = '{32'h00001234, 4'hA, 5'd31, 32'hCAFEF00D, 1'b1, 32'hCA00F000};
    vecs[5] = '{32'hFFFFFFFC, 4'h4, 5'd1,  32'h11223344, 1'b1, 32'h00220000};

    rst = 1'b1; en = 1'b0; pc_i = '0; wen_i = '0; wnum_i = '0; wd_i = '0;
    tx_if.out_ready = 1'b1;
    wait_cyc(3);
    chk("rst out_valid", tx_if.out_valid, 0);
    chk("rst out_data", tx_if.out_data, 0);
    chk("rst overflow", overflow, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    chk("rst done", done, 0);
    rst = 1'b0;
    wait_cyc(2);

    // Event sampled at edge N: valid still low after N+1, high after N+2.
    drive_ev(32'h80000000, 4'hF, 5'd5, 32'h12345678);
    push_exp(8'hA5, 32'h80000000, 5'd5, 32'h12345678);
    chk("lat N", tx_if.out_valid, 0);
    tick();
    chk("lat N+1", tx_if.out_valid, 0);
    tick();
    chk("lat N+2", tx_if.out_valid, 1);
    wait_cyc(16);
    cmp_stream("lat rec");

    foreach (vecs[i]) begin
      drive_ev(vecs[i].pc, vecs[i].wen, vecs[i].wnum, vecs[i].wdata);
      if (vecs[i].exp_rec) push_exp(8'hA5, vecs[i].pc, vecs[i].wnum, vecs[i].exp_word);
      wait_cyc(16);
      cmp_stream($sformatf("vec%0d", i));
    end

    // Short bursts (never enough to fill the FIFO) with a stuttering sink.
    for (int b = 0; b < 24; b++) begin
      k = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) begin
        pc  = $urandom;
        if (pc == END_PC) pc = pc ^ 32'h4;
        wen = 4'($urandom_range(0, 15));
        wn  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wd  = $urandom;
        if (wen != 4'h0 && wn != 5'd0) push_exp(8'hA5, pc, wn, mask_wd(wd, wen));
        tx_if.out_ready = ($urandom_range(0, 3) != 0);
        drive_ev(pc, wen, wn, wd);
      end
      for (int c = 0; c < 150; c++) begin
        tx_if.out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      tx_if.out_ready = 1'b1;
      wait_cyc(15);
      cmp_stream($sformatf("burst%0d", b));
    end
    chk("rand overflow", overflow, 0);
    chk("rand drop_cnt", drop_cnt, 0);

    // Stalled sink: the serialiser holds the first record, the FIFO keeps
    // DEPTH-1 more (one slot held for the end record), the rest are dropped.
    tx_if.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      pc = 32'h80001000 + 32'(4 * i);
      wd = $urandom;
      wn = 5'(i % 31 + 1);
      if (i < DEPTH) push_exp(8'hA5, pc, wn, wd);
      drive_ev(pc, 4'hF, wn, wd);
    end
    wait_cyc(5);
    chk("ovf overflow", overflow, 1);
    chk("ovf drop_cnt", drop_cnt, 4);
    chk("ovf held valid", tx_if.out_valid, 1);
    tx_if.out_ready = 1'b1;
    wait_cyc(DEPTH * 12 + 10);
    cmp_stream("ovf drain");

    // End PC that is also a normal write: normal record, then end record.
    drive_ev(END_PC, 4'hF, 5'd3, 32'hA1B2C3D4);
    push_exp(8'hA5, END_PC, 5'd3, 32'hA1B2C3D4);
    push_exp(8'h5A, END_PC, 5'd0, 32'h0);
    wait_cyc(35);
    cmp_stream("end");
    chk("end done", done, 1);
    chk("end valid", tx_if.out_valid, 0);
    drive_ev(32'h80000020, 4'hF, 5'd9, 32'h55AA55AA);
    drive_ev(END_PC, 4'hF, 5'd4, 32'h01020304);
    drive_ev(32'h80000024, 4'h1, 5'd2, 32'h0000000F);
    wait_cyc(30);
    cmp_stream("post end");
    chk("post done", done, 1);
    chk("post drop_cnt", drop_cnt, 4);

    rst = 1'b1;
    wait_cyc(2);
    chk("rst2 done", done, 0);
    chk("rst2 overflow", overflow, 0);
    chk("rst2 drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    tick();

    // Reset mid-record: the record is abandoned and nothing follows release.
    drive_ev(32'h80000000, 4'hF, 5'd5, 32'h12345678);
    wait_cyc(5);
    chk("mid sending", tx_if.out_valid, 1);
    #2 rst = 1'b1;
    #1 chk("mid rst valid", tx_if.out_valid, 0);
    rx_q.delete();
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(30);
    cmp_stream("mid rst quiet");
    drive_ev(32'h80000040, 4'h3, 5'd6, 32'hDEADBEEF);
    push_exp(8'hA5, 32'h80000040, 5'd6, 32'h0000BEEF);
    wait_cyc(16);
    cmp_stream("after rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
